// File: rtl/rect_pos_ctl_if.sv
// Placement request channel for rect_pos_ctl.
// Valid/ready handshake carrying the target x/y position.
interface rect_pos_ctl_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_x;
  logic [11:0] req_y;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    output req_ready
  );
endinterface

// File: rtl/rect_pos_ctl.sv
// Frame-synchronous rectangle position controller.
// Updates xpos/ypos once per frame on the vblnk rising edge.
module rect_pos_ctl #(
  parameter int          SCREEN_W = 800,
  parameter int          SCREEN_H = 600,
  parameter int          RECT_L   = 100,
  parameter int          RECT_W   = 100,
  parameter int          STEP     = 4,
  parameter logic [11:0] INIT_X   = 12'd0,
  parameter logic [11:0] INIT_Y   = 12'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vblnk,
  input  logic         bounce_en,
  rect_pos_ctl_if.slave req,
  output logic [11:0]  xpos,
  output logic [11:0]  ypos,
  output logic         frame_upd
);

  localparam logic signed [12:0] XMAX =
    13'(SCREEN_W - 1 - RECT_L);
  localparam logic signed [12:0] YMAX =
    13'(SCREEN_H - 1 - RECT_W);
  localparam logic signed [12:0] STEP_S =
    13'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  typedef struct packed {
    logic        neg;
    logic [11:0] pos;
  } axis_t;

  state_t      state;
  logic        pend;
  logic        vblnk_d;
  logic        dir_x_neg;
  logic        dir_y_neg;
  logic [11:0] req_x_q;
  logic [11:0] req_y_q;
  logic        rise;
  logic        accept;
  axis_t       nx;
  axis_t       ny;
  logic [11:0] cx;
  logic [11:0] cy;

  // One bounce step on one axis; reflects at 0 and at lim.
  function automatic axis_t step_axis(
    input logic [11:0]        pos,
    input logic               neg,
    input logic signed [12:0] lim
  );
    logic signed [12:0] p;
    logic signed [12:0] n;
    axis_t r;
    p = $signed({1'b0, pos});
    n = p;
    r.neg = neg;
    r.pos = pos;
    if (!neg) begin
      n = p + STEP_S;
      if (n >= lim) begin
        r.pos = lim[11:0];
        r.neg = 1'b1;
      end else begin
        r.pos = n[11:0];
      end
    end else if (p <= STEP_S) begin
      r.pos = 12'd0;
      r.neg = 1'b0;
    end else begin
      n = p - STEP_S;
      r.pos = n[11:0];
    end
    return r;
  endfunction

  assign rise   = vblnk & ~vblnk_d;
  assign accept = req.req_valid & req.req_ready;
  assign nx     = step_axis(xpos, dir_x_neg, XMAX);
  assign ny     = step_axis(ypos, dir_y_neg, YMAX);

  assign cx = ($signed({1'b0, req_x_q}) > XMAX)
            ? XMAX[11:0] : req_x_q;
  assign cy = ($signed({1'b0, req_y_q}) > YMAX)
            ? YMAX[11:0] : req_y_q;

  // Edge detect, request capture and ready (drops on accept).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d       <= 1'b0;
      req.req_ready <= 1'b0;
      req_x_q       <= 12'd0;
      req_y_q       <= 12'd0;
    end else begin
      vblnk_d       <= vblnk;
      req.req_ready <= !pend && !accept;
      if (accept) begin
        req_x_q <= req.req_x;
        req_y_q <= req.req_y;
      end
    end
  end

  // Frame FSM: one position update per vblnk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
      xpos      <= INIT_X;
      ypos      <= INIT_Y;
      frame_upd <= 1'b0;
    end else begin
      frame_upd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) state <= CALC;
        end
        CALC: begin
          frame_upd <= 1'b1;
          if (pend) begin
            xpos <= cx;
            ypos <= cy;
            pend <= 1'b0;
          end else if (bounce_en) begin
            xpos      <= nx.pos;
            ypos      <= ny.pos;
            dir_x_neg <= nx.neg;
            dir_y_neg <= ny.neg;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (!vblnk) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rect_pos_ctl.sv
// Self-checking bench for rect_pos_ctl.
// Frame-level reference model with a request queue.
module tb_rect_pos_ctl;
  localparam int XMAX = 699;
  localparam int YMAX = 499;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk = 1'b0;
  logic        bounce_en = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        frame_upd;

  rect_pos_ctl_if bus();

  rect_pos_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk     (vblnk),
    .bounce_en (bounce_en),
    .req       (bus),
    .xpos      (xpos),
    .ypos      (ypos),
    .frame_upd (frame_upd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mx, my, mdx, mdy;
  int qx[$];
  int qy[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    mx = 0; my = 0; mdx = 1; mdy = 1;
    qx.delete(); qy.delete();
  endfunction

  function automatic void axis(inout int p,
                               inout int d,
                               input int lim);
    if (d > 0) begin
      if (p + STEP >= lim) begin
        p = lim; d = -1;
      end else p = p + STEP;
    end else if (p <= STEP) begin
      p = 0; d = 1;
    end else p = p - STEP;
  endfunction

  function automatic void model_frame(input bit bnc);
    if (qx.size() > 0) begin
      int x = qx.pop_front();
      int y = qy.pop_front();
      mx = (x > XMAX) ? XMAX : x;
      my = (y > YMAX) ? YMAX : y;
    end else if (bnc) begin
      axis(mx, mdx, XMAX);
      axis(my, mdy, YMAX);
    end
  endfunction

  task automatic send_req(input int x, input int y);
    bit acc = 0;
    bus.req_valid = 1'b1;
    bus.req_x = 12'(x);
    bus.req_y = 12'(y);
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL req_accept (%0d,%0d): ready=0 required 1",
               x, y);
    end else begin
      qx.push_back(x);
      qy.push_back(y);
    end
  endtask

  task automatic frame(input string tag, input int hold);
    int pulses = 0;
    vblnk = 1'b1;
    tick();
    pulses += int'(frame_upd === 1'b1);
    total++;
    if (xpos !== 12'(mx) || ypos !== 12'(my)) begin
      bad++;
      $display("FAIL %s early: got %0d,%0d required %0d,%0d",
               tag, xpos, ypos, mx, my);
    end
    model_frame(bounce_en);
    tick();
    pulses += int'(frame_upd === 1'b1);
    total++;
    if (xpos !== 12'(mx) || ypos !== 12'(my)) begin
      bad++;
      $display("FAIL %s pos: got %0d,%0d required %0d,%0d",
               tag, xpos, ypos, mx, my);
    end
    total++;
    if (frame_upd !== 1'b1) begin
      bad++;
      $display("FAIL %s upd: got %b required 1",
               tag, frame_upd);
    end
    for (int i = 2; i < hold; i++) begin
      tick();
      pulses += int'(frame_upd === 1'b1);
    end
    vblnk = 1'b0;
    tick();
    pulses += int'(frame_upd === 1'b1);
    tick();
    pulses += int'(frame_upd === 1'b1);
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL %s pulses: got %0d required 1",
               tag, pulses);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (xpos !== 12'd0 || ypos !== 12'd0 ||
        bus.req_ready !== 1'b0 || frame_upd !== 1'b0) begin
      bad++;
      $display("FAIL reset: x=%0d y=%0d rdy=%b upd=%b req 0",
               xpos, ypos, bus.req_ready, frame_upd);
    end
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_early: got %b required 0",
               bus.req_ready);
    end
    tick();
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_release: got %b required 1",
               bus.req_ready);
    end
  endtask

  task automatic test_placement();
    bounce_en = 1'b0;
    repeat (3) tick();
    send_req(300, 200);
    repeat (4) tick();
    total++;
    if (xpos !== 12'd0 || ypos !== 12'd0 ||
        bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL place_hold: x=%0d y=%0d rdy=%b req 0,0,0",
               xpos, ypos, bus.req_ready);
    end
    frame("place", 4);
    total++;
    if (xpos !== 12'd300 || ypos !== 12'd200 ||
        bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL place: x=%0d y=%0d rdy=%b req 300,200,1",
               xpos, ypos, bus.req_ready);
    end
  endtask

  task automatic test_clamp();
    send_req(790, 590);
    tick();
    frame("clamp", 3);
    total++;
    if (xpos !== 12'd699 || ypos !== 12'd499) begin
      bad++;
      $display("FAIL clamp: got %0d,%0d required 699,499",
               xpos, ypos);
    end
  endtask

  task automatic test_bounce();
    bounce_en = 1'b0;
    send_req(696, 0);
    frame("b_place", 2);
    bounce_en = 1'b1;
    frame("b1", 3);
    total++;
    if (xpos !== 12'd699 || ypos !== 12'd4) begin
      bad++;
      $display("FAIL bounce_max: got %0d,%0d required 699,4",
               xpos, ypos);
    end
    frame("b2", 2);
    frame("b3", 2);
    total++;
    if (xpos !== 12'd691) begin
      bad++;
      $display("FAIL bounce_dn: got %0d required 691", xpos);
    end
    send_req(3, 100);
    frame("b_place2", 2);
    frame("b4", 2);
    total++;
    if (xpos !== 12'd0) begin
      bad++;
      $display("FAIL bounce_zero: got %0d required 0", xpos);
    end
    frame("b5", 2);
    total++;
    if (xpos !== 12'd4) begin
      bad++;
      $display("FAIL bounce_up: got %0d required 4", xpos);
    end
    for (int i = 0; i < 4; i++) frame("bn", 2);
  endtask

  task automatic test_collision();
    bit acc = 0;
    bounce_en = 1'b0;
    send_req(100, 50);
    bus.req_valid = 1'b1;
    bus.req_x = 12'd200;
    bus.req_y = 12'd60;
    vblnk = 1'b1;
    tick();
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL coll_rdy0: got %b required 0",
               bus.req_ready);
    end
    model_frame(1'b0);
    tick();
    total++;
    if (xpos !== 12'(mx) || ypos !== 12'(my) ||
        frame_upd !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL coll_first: x=%0d y=%0d u=%b r=%b req %0d,%0d,1,0",
               xpos, ypos, frame_upd, bus.req_ready, mx, my);
    end
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL coll_accept: ready=0 required 1");
    end else begin
      qx.push_back(200);
      qy.push_back(60);
    end
    tick();
    vblnk = 1'b0;
    repeat (3) tick();
    total++;
    if (xpos !== 12'd100 || ypos !== 12'd50) begin
      bad++;
      $display("FAIL coll_wait: got %0d,%0d required 100,50",
               xpos, ypos);
    end
    frame("coll2", 3);
    vblnk = 1'b1;
    tick();
    bus.req_valid = 1'b1;
    bus.req_x = 12'd321;
    bus.req_y = 12'd123;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL late_rdy: got %b required 1",
               bus.req_ready);
    end
    model_frame(1'b0);
    tick();
    bus.req_valid = 1'b0;
    qx.push_back(321);
    qy.push_back(123);
    total++;
    if (xpos !== 12'(mx) || ypos !== 12'(my) ||
        frame_upd !== 1'b1) begin
      bad++;
      $display("FAIL late_calc: x=%0d y=%0d u=%b req %0d,%0d,1",
               xpos, ypos, frame_upd, mx, my);
    end
    repeat (2) tick();
    vblnk = 1'b0;
    repeat (2) tick();
    frame("late_apply", 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      bounce_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        send_req(int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 4095)));
      repeat ($urandom_range(1, 5)) tick();
      frame("rand", int'($urandom_range(2, 6)));
      repeat (2) tick();
    end
  endtask

  task automatic test_long_vblnk();
    bounce_en = 1'b1;
    frame("long", 20);
  endtask

  task automatic test_reset_in_calc();
    int pulses = 0;
    bounce_en = 1'b1;
    vblnk = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (xpos !== 12'd0 || ypos !== 12'd0 ||
        bus.req_ready !== 1'b0 || frame_upd !== 1'b0) begin
      bad++;
      $display("FAIL rst_calc: x=%0d y=%0d r=%b u=%b req 0",
               xpos, ypos, bus.req_ready, frame_upd);
    end
    tick();
    pulses += int'(frame_upd === 1'b1);
    vblnk = 1'b0;
    tick();
    pulses += int'(frame_upd === 1'b1);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      pulses += int'(frame_upd === 1'b1);
    end
    total++;
    if (pulses != 0 || xpos !== 12'd0 || ypos !== 12'd0) begin
      bad++;
      $display("FAIL rst_noupd: p=%0d x=%0d y=%0d req 0,0,0",
               pulses, xpos, ypos);
    end
    frame("after_rst", 3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_x = 12'd0;
    bus.req_y = 12'd0;
    model_reset();
    test_reset();
    test_placement();
    test_clamp();
    test_bounce();
    test_collision();
    test_random();
    test_long_vblnk();
    test_reset_in_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
